// File: rtl/lathe_pkg.sv
// Shared types for the lathe cycle sequencer: state encoding, fault codes,
// and a small helper used to size the shared timer.
package lathe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPINUP  = 3'd1,
    ST_FEED    = 3'd2,
    ST_RUNDOWN = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ESTOP   = 3'd1;
  localparam logic [2:0] FC_GUARD   = 3'd2;
  localparam logic [2:0] FC_WDOG    = 3'd3;
  localparam logic [2:0] FC_COOLANT = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lathe_timer.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
module lathe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/lathe_cycle_seq.sv
// Lathe machining-cycle sequencer: IDLE -> SPINUP -> FEED -> RUNDOWN with
// interlock faults. Define LATHE_COOLANT_EN to enable coolant drive and fault.
module lathe_cycle_seq
  import lathe_pkg::*;
#(
  parameter int SPINUP_CYC   = 20,
  parameter int FEED_TIMEOUT = 200,
  parameter int RUNDOWN_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle_start,
  input  logic       estop,
  input  logic       guard_closed,
  input  logic       feed_done,
  input  logic       coolant_ok,
  input  logic       fault_clr,
  output logic       spindle_on,
  output logic       feed_en,
  output logic       coolant_on,
  output logic       busy,
  output logic       cycle_done,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  localparam int TW = $clog2(max3(SPINUP_CYC, FEED_TIMEOUT, RUNDOWN_CYC)) + 1;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [2:0]    fault_r;
  logic [2:0]    fault_nxt_s;
  logic          start_q_r;
  logic          armed_r;
  logic          rise_s;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_done_s;
  logic          coolant_fault_s;
  logic          coolant_dec_s;
  logic          spindle_r;
  logic          feed_r;
  logic          coolant_r;
  logic          busy_r;
  logic          done_r;

`ifdef LATHE_COOLANT_EN
  assign coolant_fault_s = ~coolant_ok;
  assign coolant_dec_s   = (state_nxt_s == ST_SPINUP) || (state_nxt_s == ST_FEED);
`else
  logic coolant_unused_s;
  assign coolant_unused_s = coolant_ok;
  assign coolant_fault_s  = 1'b0;
  assign coolant_dec_s    = 1'b0;
`endif

  // A start button held through reset must be released before it can arm a cycle.
  assign rise_s = cycle_start & ~start_q_r & armed_r;

  // Next-state and fault-cause selection; priority estop > guard > coolant > feed_done > watchdog.
  always_comb begin
    state_nxt_s = state_r;
    fault_nxt_s = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (estop) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_ESTOP;
        end else if (rise_s && guard_closed) begin
          state_nxt_s = ST_SPINUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SPINUP: begin
        if (estop) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_ESTOP;
        end else if (!guard_closed) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_GUARD;
        end else if (tmr_done_s) begin
          state_nxt_s = ST_FEED;
        end else begin
          state_nxt_s = ST_SPINUP;
        end
      end
      ST_FEED: begin
        if (estop) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_ESTOP;
        end else if (!guard_closed) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_GUARD;
        end else if (coolant_fault_s) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_COOLANT;
        end else if (feed_done) begin
          state_nxt_s = ST_RUNDOWN;
        end else if (tmr_done_s) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_WDOG;
        end else begin
          state_nxt_s = ST_FEED;
        end
      end
      ST_RUNDOWN: begin
        if (estop) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_ESTOP;
        end else if (!guard_closed) begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = FC_GUARD;
        end else if (tmr_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUNDOWN;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !estop && guard_closed && !cycle_start) begin
          state_nxt_s = ST_IDLE;
          fault_nxt_s = FC_NONE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_FAULT;
        fault_nxt_s = fault_r;
      end
    endcase
  end

  // Timer reload value for the state being entered; counts N-1..0 to give N cycles.
  always_comb begin
    tmr_load_s = (state_nxt_s != state_r);
    case (state_nxt_s)
      ST_SPINUP:  tmr_val_s = TW'(SPINUP_CYC - 1);
      ST_FEED:    tmr_val_s = TW'(FEED_TIMEOUT - 1);
      ST_RUNDOWN: tmr_val_s = TW'(RUNDOWN_CYC - 1);
      default:    tmr_val_s = {TW{1'b0}};
    endcase
  end

  lathe_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // State register plus registered Moore decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      fault_r   <= FC_NONE;
      start_q_r <= 1'b0;
      armed_r   <= 1'b0;
      spindle_r <= 1'b0;
      feed_r    <= 1'b0;
      coolant_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      fault_r   <= fault_nxt_s;
      start_q_r <= cycle_start;
      armed_r   <= armed_r | ~cycle_start;
      spindle_r <= (state_nxt_s == ST_SPINUP) || (state_nxt_s == ST_FEED);
      feed_r    <= (state_nxt_s == ST_FEED);
      coolant_r <= coolant_dec_s;
      busy_r    <= (state_nxt_s == ST_SPINUP) || (state_nxt_s == ST_FEED) ||
                   (state_nxt_s == ST_RUNDOWN);
      done_r    <= (state_r == ST_RUNDOWN) && (state_nxt_s == ST_IDLE);
    end
  end

  // Emergency stop gates the drives without waiting for a clock edge.
  assign spindle_on = spindle_r & ~estop;
  assign feed_en    = feed_r & ~estop;
  assign coolant_on = coolant_r & ~estop;
  assign busy       = busy_r;
  assign cycle_done = done_r;
  assign fault_code = fault_r;
  assign state      = state_r;

endmodule

// File: tb/tb_lathe_cycle_seq.sv
// Directed self-checking bench for lathe_cycle_seq (default parameters).
// Coolant expectations follow LATHE_COOLANT_EN.
module tb_lathe_cycle_seq;

  logic       clk = 1'b0;
  logic       reset, cycle_start, estop, guard_closed, feed_done, coolant_ok, fault_clr;
  logic       spindle_on, feed_en, coolant_on, busy, cycle_done;
  logic [2:0] fault_code, state;
  int         checks = 0;
  int         failures = 0;

  lathe_cycle_seq dut (
    .clk(clk), .reset(reset), .cycle_start(cycle_start), .estop(estop),
    .guard_closed(guard_closed), .feed_done(feed_done), .coolant_ok(coolant_ok),
    .fault_clr(fault_clr), .spindle_on(spindle_on), .feed_en(feed_en),
    .coolant_on(coolant_on), .busy(busy), .cycle_done(cycle_done),
    .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

`ifdef LATHE_COOLANT_EN
  localparam int COOL = 1;
`else
  localparam int COOL = 0;
`endif

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output vector: state, spindle, feed, coolant, busy, cycle_done, fault_code.
  task automatic outs(input string tag, input int st, input int sp, input int fe,
                      input int co, input int bs, input int cd, input int fc);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".spindle"}, int'(spindle_on), sp);
    chk({tag, ".feed"}, int'(feed_en), fe);
    chk({tag, ".coolant"}, int'(coolant_on), co);
    chk({tag, ".busy"}, int'(busy), bs);
    chk({tag, ".done"}, int'(cycle_done), cd);
    chk({tag, ".fcode"}, int'(fault_code), fc);
  endtask

  initial begin
    reset = 1'b1; cycle_start = 1'b0; estop = 1'b0; guard_closed = 1'b1;
    feed_done = 1'b0; coolant_ok = 1'b1; fault_clr = 1'b0;
    #12;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(2);
    outs("idle", 0, 0, 0, 0, 0, 0, 0);

    // Normal cycle: 20 SPINUP, feed_done in FEED cycle 50, 10 RUNDOWN.
    cycle_start = 1'b1;
    tick(1);
    outs("spin1", 1, 1, 0, COOL, 1, 0, 0);
    tick(19);
    outs("spin20", 1, 1, 0, COOL, 1, 0, 0);
    tick(1);
    outs("feed1", 2, 1, 1, COOL, 1, 0, 0);
    tick(49);
    outs("feed50", 2, 1, 1, COOL, 1, 0, 0);
    feed_done = 1'b1;
    tick(1);
    feed_done = 1'b0;
    outs("rd1", 3, 0, 0, 0, 1, 0, 0);
    tick(9);
    outs("rd10", 3, 0, 0, 0, 1, 0, 0);
    tick(1);
    outs("done", 0, 0, 0, 0, 0, 1, 0);
    tick(1);
    outs("done_off", 0, 0, 0, 0, 0, 0, 0);
    tick(5);
    chk("held_start", int'(state), 0);
    cycle_start = 1'b0;
    tick(1);

    // Watchdog: no feed_done for 200 FEED cycles.
    cycle_start = 1'b1;
    tick(21);
    chk("wd_feed1", int'(state), 2);
    tick(199);
    outs("wd_feed200", 2, 1, 1, COOL, 1, 0, 0);
    tick(1);
    outs("wd_fault", 4, 0, 0, 0, 0, 0, 3);
    fault_clr = 1'b1;
    tick(1);
    chk("wd_clr_start_hi", int'(state), 4);
    cycle_start = 1'b0;
    tick(1);
    outs("wd_clr", 0, 0, 0, 0, 0, 0, 0);
    fault_clr = 1'b0;

    // Estop in FEED cycle 5 removes drives without a clock edge.
    cycle_start = 1'b1;
    tick(21);
    tick(4);
    chk("es_feed5", int'(state), 2);
    estop = 1'b1;
    #1;
    chk("es_spindle_comb", int'(spindle_on), 0);
    chk("es_feed_comb", int'(feed_en), 0);
    cycle_start = 1'b0;
    tick(1);
    outs("es_fault", 4, 0, 0, 0, 0, 0, 1);
    fault_clr = 1'b1;
    tick(2);
    outs("es_clr_blocked", 4, 0, 0, 0, 0, 0, 1);
    estop = 1'b0;
    tick(1);
    outs("es_clr", 0, 0, 0, 0, 0, 0, 0);
    fault_clr = 1'b0;

    // Estop and guard open together in SPINUP: estop wins.
    cycle_start = 1'b1;
    tick(4);
    chk("pri_spin", int'(state), 1);
    estop = 1'b1; guard_closed = 1'b0;
    tick(1);
    outs("pri_fault", 4, 0, 0, 0, 0, 0, 1);
    estop = 1'b0; guard_closed = 1'b1; cycle_start = 1'b0; fault_clr = 1'b1;
    tick(1);
    chk("pri_clr", int'(state), 0);
    fault_clr = 1'b0;

    // Guard open in SPINUP alone gives code 2.
    cycle_start = 1'b1;
    tick(2);
    guard_closed = 1'b0;
    tick(1);
    outs("guard_fault", 4, 0, 0, 0, 0, 0, 2);
    guard_closed = 1'b1; cycle_start = 1'b0; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;

    // Start edge with guard open in IDLE is ignored, and no fault.
    guard_closed = 1'b0; cycle_start = 1'b1;
    tick(3);
    outs("idle_guard", 0, 0, 0, 0, 0, 0, 0);
    guard_closed = 1'b1;
    tick(2);
    chk("idle_guard_noedge", int'(state), 0);
    cycle_start = 1'b0;
    tick(1);

    // Estop in IDLE faults with code 1.
    estop = 1'b1;
    tick(1);
    outs("idle_estop", 4, 0, 0, 0, 0, 0, 1);
    estop = 1'b0; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;

    // Coolant loss in FEED.
    cycle_start = 1'b1;
    tick(21);
    chk("cool_feed", int'(state), 2);
    chk("cool_drive", int'(coolant_on), COOL);
    coolant_ok = 1'b0;
    tick(1);
    if (COOL == 1) begin
      outs("cool_fault", 4, 0, 0, 0, 0, 0, 4);
      coolant_ok = 1'b1; cycle_start = 1'b0; fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
    end else begin
      outs("cool_ignored", 2, 1, 1, 0, 1, 0, 0);
      feed_done = 1'b1;
      tick(1);
      feed_done = 1'b0;
      tick(10);
      outs("cool_complete", 0, 0, 0, 0, 0, 1, 0);
      coolant_ok = 1'b1; cycle_start = 1'b0;
      tick(1);
    end
    chk("cool_after", int'(state), 0);

    // Reset pulse in RUNDOWN, start held through and after reset.
    cycle_start = 1'b1;
    tick(21);
    feed_done = 1'b1;
    tick(1);
    feed_done = 1'b0;
    tick(3);
    chk("rst_rd", int'(state), 3);
    #2;
    reset = 1'b1;
    #1;
    outs("rst_async", 0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    tick(5);
    outs("rst_held", 0, 0, 0, 0, 0, 0, 0);
    cycle_start = 1'b0;
    tick(1);
    cycle_start = 1'b1;
    tick(1);
    outs("rst_fresh", 1, 1, 0, COOL, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
